cistercian_scan_driver: RTL
===========================

# cistercian_scan_driver

Time-multiplexed driver for a row of Cistercian-numeral glyphs, one 4-bit value per digit position, each glyph drawn with five strokes U,V,W,X,Y. Generalises the fixed two-digit combinational decoder to DIGITS positions scanned over one shared stroke bus. Adds double-buffered value storage with frame-aligned commit, per-digit blink, anti-ghosting blank gaps and run-time output polarity. Sits between a peripheral register interface and the stroke/digit-select pads.

## Interface
- DIGITS, 4, number of digit positions (>= 2)
- DIV, 16, clock cycles per digit slot (>= 2)
- BLINK_FRAMES, 32, scan frames per blink half-period (>= 1)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  write wr_data into shadow[wr_idx]
- wr_idx  in  $clog2(DIGITS)  shadow index; values >= DIGITS ignored
- wr_data  in  4  digit value 0..15
- commit  in  1  request shadow-to-active copy at next frame boundary
- lamp_test  in  1  force all strokes on
- blank  in  1  force all strokes off
- blink_mask  in  DIGITS  per-digit blink enable
- seg_active_high  in  1  stroke pin polarity (1 = high lights stroke)
- dig_active_high  in  1  digit-select polarity (1 = high selects)
- seg  out  5  strokes {U,V,W,X,Y}
- dig  out  DIGITS  one-hot digit select
- frame_start  out  1  one-cycle pulse at start of slot 0
- commit_pending  out  1  commit requested, not yet applied

## Operation
- Stroke map (value -> UVWXY): 0->00000, 1->10000, 2->01000, 3->00100, 4->00010, 5->10010, 6->00001, 7->10001, 8->01001, 9->11001, 10->11110, 11->10011, 12->11101, 13->11011, 14->10111, 15->01111.
- Prescaler pre counts 0..DIV-1, wraps; on wrap slot advances 0..DIGITS-1, wraps to 0. Frame boundary = pre==DIV-1 and slot==DIGITS-1.
- Logical select: slot's bit set, except pre==0 (anti-ghost gap): all deselected.
- Logical strokes, priority: blank -> 00000; lamp_test -> 11111; blink_mask[slot] && blink_phase -> 00000; else map(active[slot]).
- Pins: seg = logical ^ {5{~seg_active_high}}; dig = logical ^ {DIGITS{~dig_active_high}}.
- Writes update shadow only. commit sets commit_pending; at frame boundary with pending set, active <= shadow (all digits), pending clears. commit while pending: no effect.
- Frame counter counts boundaries 0..BLINK_FRAMES-1; on its wrap blink_phase toggles.

## Timing
- All outputs registered: pins at cycle t+1 reflect pre/slot/state at t.
- Reset values: pre=0, slot=0, shadow=active=0, commit_pending=0, blink_phase=0, frame counter=0; seg = {5{~seg_active_high}} and dig = {DIGITS{~dig_active_high}} (all inactive), frame_start=0.
- First post-reset output cycle is slot 0 gap; select asserts DIV-1 cycles per slot.
- frame_start high exactly the cycle dig shows slot 0 gap, once per DIGITS*DIV cycles.
- Write and boundary copy same edge: copy uses pre-edge shadow; new value waits for next commit.
- commit on boundary cycle with pending clear: applied at that boundary, commit_pending never rises.
- commit_pending falls on the edge active updates; new value visible on seg from that slot.
- Reset mid-frame: scan, buffers, pending commit, blink all return to reset values next edge.
- Polarity inputs combinational into output register: change visible next cycle.

## Structure
- Package cistercian_pkg: SEG_W=5, stroke-map constant/function, stroke bit index names U..Y.
- Sub-module cistercian_stroke_lut: combinational 4-bit -> 5-bit map, one instance on the muxed active value.

## Test plan
- Reset, DIGITS=4, DIV=4, both polarities 1: seg=00000, dig=0000; frame_start every 16 cycles; dig 0001 for 3 cycles after 1 gap cycle, then 0010, 0100, 1000.
- Write shadow 0..3 = 1,10,12,15, no commit -> all slots show 00000; commit mid-frame -> pending high until boundary, then slots show 10000,11110,11101,01111.
- Write shadow[2]=7 and commit on boundary cycle -> old shadow copied; slot 2 shows 7 only after a second commit.
- blink_mask=0010, BLINK_FRAMES=2: slot 1 strokes on 2 frames, off 2 frames; lamp_test during off phase -> 11111; blank -> 00000 overriding lamp_test.
- seg_active_high=0, dig_active_high=0, value 9 on slot 0 -> seg=00110, dig=1110 during select, dig=1111 during gap.
- Assert rst during slot 2 with commit pending -> next cycle pins inactive, commit_pending=0, scan restarts at slot 0, active values zero.

Source files
------------

// File: rtl/cistercian_pkg.sv
// Shared stroke constants and value-to-stroke map for Cistercian glyph drivers.
// Pure definitions: no latency or backpressure of its own.
package cistercian_pkg;

    localparam int SEG_W = 5;

    // Bit positions of each stroke within the {U,V,W,X,Y} bus.
    localparam int STROKE_U = 4;
    localparam int STROKE_V = 3;
    localparam int STROKE_W = 2;
    localparam int STROKE_X = 1;
    localparam int STROKE_Y = 0;

    function automatic logic [SEG_W-1:0] stroke_map(input logic [3:0] val);
        logic [SEG_W-1:0] s;
        s = '0;
        case (val)
            4'd0:  s = 5'b00000;
            4'd1:  s = 5'b10000;
            4'd2:  s = 5'b01000;
            4'd3:  s = 5'b00100;
            4'd4:  s = 5'b00010;
            4'd5:  s = 5'b10010;
            4'd6:  s = 5'b00001;
            4'd7:  s = 5'b10001;
            4'd8:  s = 5'b01001;
            4'd9:  s = 5'b11001;
            4'd10: s = 5'b11110;
            4'd11: s = 5'b10011;
            4'd12: s = 5'b11101;
            4'd13: s = 5'b11011;
            4'd14: s = 5'b10111;
            4'd15: s = 5'b01111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cistercian_stroke_lut.sv
// Combinational 4-bit digit value to {U,V,W,X,Y} stroke pattern.
// Zero latency; no backpressure.
module cistercian_stroke_lut
    import cistercian_pkg::*;
(
    input  logic [3:0]       i_val,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = stroke_map(i_val);

endmodule

// File: rtl/cistercian_scan_driver.sv
// Scans DIGITS Cistercian glyphs over one shared stroke bus with frame-aligned commit.
// Pins lag scan state by one cycle; writes and commits are always accepted (no backpressure).
module cistercian_scan_driver
    import cistercian_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DIV          = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_idx,
    input  logic [3:0]                wr_data,
    input  logic                      commit,
    input  logic                      lamp_test,
    input  logic                      blank,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic                      seg_active_high,
    input  logic                      dig_active_high,
    output logic [SEG_W-1:0]          seg,
    output logic [DIGITS-1:0]         dig,
    output logic                      frame_start,
    output logic                      commit_pending
);

    localparam int SW = $clog2(DIGITS);
    localparam int PW = $clog2(DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]    r_pre;
    logic [SW-1:0]    r_slot;
    logic [FW-1:0]    r_frm;
    logic             r_blink_phase;
    logic [3:0]       r_shadow [DIGITS];
    logic [3:0]       r_active [DIGITS];

    logic             w_pre_wrap;
    logic             w_boundary;
    logic [3:0]       w_cur_val;
    logic [SEG_W-1:0] w_map;
    logic [SEG_W-1:0] w_seg_log;
    logic [DIGITS-1:0] w_dig_log;

    assign w_pre_wrap = (r_pre == PRE_LAST);
    assign w_boundary = w_pre_wrap && (r_slot == SLOT_LAST);
    assign w_cur_val  = r_active[r_slot];

    cistercian_stroke_lut u_lut (
        .i_val (w_cur_val),
        .o_seg (w_map)
    );

    always_comb begin
        w_seg_log = w_map;
        if (blank)
            w_seg_log = '0;
        else if (lamp_test)
            w_seg_log = '1;
        else if (blink_mask[r_slot] && r_blink_phase)
            w_seg_log = '0;
    end

    // First cycle of every slot is a blank gap so the previous glyph cannot ghost.
    assign w_dig_log = (r_pre == '0) ? '0 : (DIGITS'(1) << r_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre          <= '0;
            r_slot         <= '0;
            r_frm          <= '0;
            r_blink_phase  <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            seg         <= {SEG_W{~seg_active_high}};
            dig         <= {DIGITS{~dig_active_high}};
            frame_start <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
            if (w_pre_wrap)
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;

            // A commit arriving on the boundary itself is applied immediately.
            if (w_boundary) begin
                if (commit_pending || commit) begin
                    for (int i = 0; i < DIGITS; i++)
                        r_active[i] <= r_shadow[i];
                end
                commit_pending <= 1'b0;
                if (r_frm == FRM_LAST) begin
                    r_frm         <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frm <= r_frm + 1'b1;
                end
            end else if (commit) begin
                commit_pending <= 1'b1;
            end

            if (wr_en && (int'(wr_idx) < DIGITS))
                r_shadow[wr_idx] <= wr_data;

            seg         <= w_seg_log ^ {SEG_W{~seg_active_high}};
            dig         <= w_dig_log ^ {DIGITS{~dig_active_high}};
            frame_start <= (r_pre == '0) && (r_slot == '0);
        end
    end

endmodule
